pipe_stage_buf: RTL and testbench

Parametrised pipeline-stage register with valid/ready handshaking, a one-entry skid buffer, exception-driven flush and a saturating back-pressure counter. It replaces the fixed-width, global-stall-vector stage registers between pipeline stages (IF/ID first, then ID/EX and onward). Each instance carries PC, instruction word and exception-type fields plus an opaque sideband. It breaks the combinational ready path between stages without losing throughput.

---
 rtl/pipe_pkg.sv | 31 +++
 rtl/pipe_sat_cnt.sv | 24 ++
 rtl/pipe_stage_buf.sv | 115 +++++++++++
 tb/tb_pipe_stage_buf.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline-stage registers: stage states, default
// field widths and the exception-type codes also used by the exception unit.
package pipe_pkg;

  localparam int unsigned PIPE_PC_W    = 32;
  localparam int unsigned PIPE_INSTR_W = 32;
  localparam int unsigned PIPE_EXC_W   = 32;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_BUSY  = 2'd1,
    ST_FULL  = 2'd2
  } pipe_state_t;

  // One-hot exception-type codes carried in the exc field; zero means none.
  localparam logic [PIPE_EXC_W-1:0] EXC_NONE    = 32'h0000_0000;
  localparam logic [PIPE_EXC_W-1:0] EXC_INT     = 32'h0000_0001;
  localparam logic [PIPE_EXC_W-1:0] EXC_ADEL    = 32'h0000_0010;
  localparam logic [PIPE_EXC_W-1:0] EXC_ADES    = 32'h0000_0020;
  localparam logic [PIPE_EXC_W-1:0] EXC_SYSCALL = 32'h0000_0100;
  localparam logic [PIPE_EXC_W-1:0] EXC_BREAK   = 32'h0000_0200;
  localparam logic [PIPE_EXC_W-1:0] EXC_RI      = 32'h0000_0400;
  localparam logic [PIPE_EXC_W-1:0] EXC_OV      = 32'h0000_1000;
  localparam logic [PIPE_EXC_W-1:0] EXC_ERET    = 32'h0000_4000;

  // An all-zero instruction word is the NOP bubble.
  function automatic logic pipe_is_nop(input logic [PIPE_INSTR_W-1:0] instr);
    return (instr == '0);
  endfunction

endpackage

// File: rtl/pipe_sat_cnt.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module pipe_sat_cnt #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != CNT_MAX)) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/pipe_stage_buf.sv
// Pipeline-stage register with valid/ready handshake, one-entry skid buffer,
// flush and a saturating back-pressure counter. All outputs come from flops.
module pipe_stage_buf
  import pipe_pkg::*;
#(
  parameter int unsigned PC_W    = PIPE_PC_W,
  parameter int unsigned INSTR_W = PIPE_INSTR_W,
  parameter int unsigned EXC_W   = PIPE_EXC_W,
  parameter int unsigned SIDE_W  = 1,
  parameter int unsigned CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [PC_W-1:0]    in_pc,
  input  logic [INSTR_W-1:0] in_instr,
  input  logic [EXC_W-1:0]   in_exc,
  input  logic [SIDE_W-1:0]  in_side,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [PC_W-1:0]    out_pc,
  output logic [INSTR_W-1:0] out_instr,
  output logic [EXC_W-1:0]   out_exc,
  output logic [SIDE_W-1:0]  out_side,
  input  logic               stall_clr,
  output logic [CNT_W-1:0]   stall_cnt
);

  localparam int unsigned PAY_W = SIDE_W + EXC_W + INSTR_W + PC_W;

  pipe_state_t      state_q;
  logic [PAY_W-1:0] main_q;
  logic [PAY_W-1:0] skid_q;
  logic [PAY_W-1:0] in_pay;
  logic             in_fire;

  assign in_pay  = {in_side, in_exc, in_instr, in_pc};
  assign in_fire = in_valid & in_ready & ~flush;

  // in_ready/out_valid are registered alongside the state so neither depends
  // combinationally on out_ready; inside BUSY/FULL out_valid=1, so out_fire
  // reduces to out_ready.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_EMPTY;
      main_q    <= '0;
      skid_q    <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else if (flush) begin
      state_q   <= ST_EMPTY;
      main_q    <= '0;
      skid_q    <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (in_fire) begin
            main_q    <= in_pay;
            state_q   <= ST_BUSY;
            out_valid <= 1'b1;
          end
        end
        ST_BUSY: begin
          if (in_fire && out_ready) begin
            main_q <= in_pay;
          end else if (in_fire) begin
            skid_q   <= in_pay;
            state_q  <= ST_FULL;
            in_ready <= 1'b0;
          end else if (out_ready) begin
            main_q    <= '0;
            state_q   <= ST_EMPTY;
            out_valid <= 1'b0;
          end
        end
        ST_FULL: begin
          if (out_ready) begin
            main_q   <= skid_q;
            skid_q   <= '0;
            state_q  <= ST_BUSY;
            in_ready <= 1'b1;
          end
        end
        default: begin
          state_q   <= ST_EMPTY;
          main_q    <= '0;
          skid_q    <= '0;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

  // Main register is zeroed whenever invalid, so out_* reads as a NOP bubble.
  assign out_pc    = main_q[PC_W-1:0];
  assign out_instr = main_q[PC_W +: INSTR_W];
  assign out_exc   = main_q[PC_W + INSTR_W +: EXC_W];
  assign out_side  = main_q[PAY_W-1 -: SIDE_W];

  pipe_sat_cnt #(
    .CNT_W (CNT_W)
  ) u_stall_cnt (
    .clk (clk),
    .rst (rst),
    .clr (stall_clr),
    .inc (out_valid & ~out_ready),
    .cnt (stall_cnt)
  );

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Directed bench for pipe_stage_buf with an expected-entry scoreboard.
module tb_pipe_stage_buf;

  localparam int unsigned CNT_W = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [31:0]       in_pc;
  logic [31:0]       in_instr;
  logic [31:0]       in_exc;
  logic [0:0]        in_side;
  logic              out_valid;
  logic              out_ready;
  logic [31:0]       out_pc;
  logic [31:0]       out_instr;
  logic [31:0]       out_exc;
  logic [0:0]        out_side;
  logic              stall_clr;
  logic [CNT_W-1:0]  stall_cnt;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] exc;
    logic        side;
  } ent_t;

  ent_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  pipe_stage_buf #(
    .PC_W (32), .INSTR_W (32), .EXC_W (32), .SIDE_W (1), .CNT_W (CNT_W)
  ) dut (
    .clk (clk), .rst (rst), .flush (flush),
    .in_valid (in_valid), .in_ready (in_ready),
    .in_pc (in_pc), .in_instr (in_instr), .in_exc (in_exc), .in_side (in_side),
    .out_valid (out_valid), .out_ready (out_ready),
    .out_pc (out_pc), .out_instr (out_instr), .out_exc (out_exc), .out_side (out_side),
    .stall_clr (stall_clr), .stall_cnt (stall_cnt)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs, check handshake flags and any leaving entry,
  // record the entry the stage is expected to accept, then advance.
  task automatic step(input logic v, input logic [31:0] pc, input logic [31:0] instr,
                      input logic [31:0] exc, input logic ordy, input logic fl,
                      input logic clr, input logic exp_ir, input logic exp_ov);
    ent_t e;
    in_valid = v; in_pc = pc; in_instr = instr; in_exc = exc; in_side = pc[2];
    out_ready = ordy; flush = fl; stall_clr = clr;
    chk("in_ready", 64'(in_ready), 64'(exp_ir));
    chk("out_valid", 64'(out_valid), 64'(exp_ov));
    if (out_valid && out_ready) begin
      if (sb.size() == 0) begin
        chk("sb_underflow", 64'(out_pc), 64'hDEAD);
      end else begin
        e = sb.pop_front();
        chk("sb_pc", 64'(out_pc), 64'(e.pc));
        chk("sb_instr", 64'(out_instr), 64'(e.instr));
        chk("sb_exc", 64'(out_exc), 64'(e.exc));
        chk("sb_side", 64'(out_side), 64'(e.side));
      end
    end
    if (v && exp_ir && !fl) begin
      e.pc = pc; e.instr = instr; e.exc = exc; e.side = pc[2];
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic ordy, input logic exp_ov);
    step(1'b0, 32'h0, 32'h0, 32'h0, ordy, 1'b0, 1'b0, 1'b1, exp_ov);
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_pc = '0; in_instr = '0;
    in_exc = '0; in_side = '0; out_ready = 1'b0; stall_clr = 1'b0;
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_pc", 64'(out_pc), 64'd0);
    chk("rst_stall_cnt", 64'(stall_cnt), 64'd0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;

    // Asynchronous reset with a live entry in the main register
    step(1'b1, 32'h100, 32'h2402_0001, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("mid_pc_loaded", 64'(out_pc), 64'h100);
    chk("mid_instr_loaded", 64'(out_instr), 64'h2402_0001);
    in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("arst_out_valid", 64'(out_valid), 64'd0);
    chk("arst_out_pc", 64'(out_pc), 64'd0);
    chk("arst_out_instr", 64'(out_instr), 64'd0);
    chk("arst_in_ready", 64'(in_ready), 64'd1);
    chk("arst_stall_cnt", 64'(stall_cnt), 64'd0);
    sb.delete();
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;

    // Streaming at full rate
    step(1'b1, 32'h0, 32'h1111_0000, 32'h0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b1, 32'h4, 32'h1111_0004, 32'h0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    step(1'b1, 32'h8, 32'h1111_0008, 32'h0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    idle(1'b1, 1'b1);
    idle(1'b1, 1'b0);
    chk("stream_stall_cnt", 64'(stall_cnt), 64'd0);

    // Back-pressure: 0x14 lands in skid, 0x18 held upstream until room
    step(1'b1, 32'h10, 32'h2222_0010, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b1, 32'h14, 32'h2222_0014, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    chk("bp_hold_pc", 64'(out_pc), 64'h10);
    step(1'b1, 32'h18, 32'h2222_0018, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("bp_hold_pc2", 64'(out_pc), 64'h10);
    step(1'b1, 32'h18, 32'h2222_0018, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b1, 32'h18, 32'h2222_0018, 32'h0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    idle(1'b1, 1'b1);
    idle(1'b1, 1'b0);
    chk("bp_stall_cnt", 64'(stall_cnt), 64'd2);
    chk("bp_sb_empty", 64'(sb.size()), 64'd0);

    // Flush in FULL with an incoming entry
    step(1'b0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    step(1'b1, 32'h30, 32'h3333_0030, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b1, 32'h34, 32'h3333_0034, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    step(1'b1, 32'h20, 32'h3333_0020, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    sb.delete();
    chk("fl_out_valid", 64'(out_valid), 64'd0);
    chk("fl_out_pc", 64'(out_pc), 64'd0);
    chk("fl_out_instr", 64'(out_instr), 64'd0);
    chk("fl_in_ready", 64'(in_ready), 64'd1);
    chk("fl_keeps_stall_cnt", 64'(stall_cnt), 64'd2);
    idle(1'b1, 1'b0);
    idle(1'b1, 1'b0);

    // Flush in BUSY discards an entry offered while in_ready=1
    step(1'b1, 32'h40, 32'h4444_0040, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b1, 32'h44, 32'h4444_0044, 32'h0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
    sb.delete();
    idle(1'b1, 1'b0);
    chk("flb_out_pc", 64'(out_pc), 64'd0);

    // Counter saturation and clear-over-increment
    step(1'b0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    chk("cnt_cleared", 64'(stall_cnt), 64'd0);
    step(1'b1, 32'h50, 32'h5555_0050, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 14; i++) idle(1'b0, 1'b1);
    chk("cnt_14", 64'(stall_cnt), 64'd14);
    for (int i = 0; i < 6; i++) idle(1'b0, 1'b1);
    chk("cnt_sat", 64'(stall_cnt), 64'd15);
    step(1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    chk("cnt_clr_prio", 64'(stall_cnt), 64'd0);
    idle(1'b1, 1'b1);
    idle(1'b1, 1'b0);

    // Exception field passthrough and zeroing after drain
    step(1'b1, 32'hBFC0_0000, 32'h0000_000C, 32'h0000_0100, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("exc_out_exc", 64'(out_exc), 64'h100);
    chk("exc_out_pc", 64'(out_pc), 64'hBFC0_0000);
    idle(1'b1, 1'b1);
    chk("exc_drain_exc", 64'(out_exc), 64'd0);
    chk("exc_drain_pc", 64'(out_pc), 64'd0);
    chk("exc_drain_valid", 64'(out_valid), 64'd0);
    chk("final_sb_empty", 64'(sb.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
